// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: pixel-enable from the clock logic, sync pins and
// pixel coordinates/blanking/strobes toward the monitor and renderers.
interface vga_timing_gen_if #(
   parameter int unsigned XW = 10,
   parameter int unsigned YW = 10
);
   logic          pix_en;
   logic          hSync;
   logic          vSync;
   logic          video_on;
   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic          line_start;
   logic          frame_start;

   modport master (
      input  pix_en,
      output hSync, vSync, video_on, x, y, line_start, frame_start
   );

   modport slave (
      output pix_en,
      input  hSync, vSync, video_on, x, y, line_start, frame_start
   );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with registered outputs decoded
// from the next-state counters, so outputs track the held position without lag.
module vga_timing_gen #(
   parameter int unsigned H_VISIBLE = 640,
   parameter int unsigned H_FP      = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BP      = 48,
   parameter int unsigned V_VISIBLE = 480,
   parameter int unsigned V_FP      = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BP      = 33,
   parameter logic        H_POL     = 1'b0,
   parameter logic        V_POL     = 1'b0,
   parameter int unsigned XW        = 10,
   parameter int unsigned YW        = 10
) (
   input  logic              clk_25,
   input  logic              rst_n,
   vga_timing_gen_if.master  vga
);
   localparam int unsigned H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HCW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
   localparam int unsigned VCW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
   localparam int unsigned HS_START = H_VISIBLE + H_FP;
   localparam int unsigned HS_STOP  = HS_START + H_SYNC;
   localparam int unsigned VS_START = V_VISIBLE + V_FP;
   localparam int unsigned VS_STOP  = VS_START + V_SYNC;

   if (XW < $clog2(H_VISIBLE)) begin : g_xw_chk
      $error("vga_timing_gen: XW too narrow for H_VISIBLE");
   end
   if (YW < $clog2(V_VISIBLE)) begin : g_yw_chk
      $error("vga_timing_gen: YW too narrow for V_VISIBLE");
   end

   logic [HCW-1:0] hc_q, hc_d;
   logic [VCW-1:0] vc_q, vc_d;
   logic [31:0]    hc_n, vc_n;
   logic           vis;
   logic           hsync_q, hsync_d;
   logic           vsync_q, vsync_d;
   logic           video_on_q, video_on_d;
   logic [XW-1:0]  x_q, x_d;
   logic [YW-1:0]  y_q, y_d;
   logic           line_start_q, line_start_d;
   logic           frame_start_q, frame_start_d;

   always_comb begin
      hc_d = hc_q;
      vc_d = vc_q;
      if (vga.pix_en) begin
         if (hc_q == HCW'(H_TOTAL - 1)) begin
            hc_d = '0;
            if (vc_q == VCW'(V_TOTAL - 1)) vc_d = '0;
            else                           vc_d = vc_q + VCW'(1);
         end else begin
            hc_d = hc_q + HCW'(1);
         end
      end

      hc_n = 32'(hc_d);
      vc_n = 32'(vc_d);
      vis  = (hc_n < H_VISIBLE) && (vc_n < V_VISIBLE);

      // Levels are only reloaded on enabled clocks so the reset levels
      // survive idle clocks even when the reset position lies in a sync window.
      hsync_d    = hsync_q;
      vsync_d    = vsync_q;
      video_on_d = video_on_q;
      x_d        = x_q;
      y_d        = y_q;
      if (vga.pix_en) begin
         hsync_d    = (hc_n >= HS_START && hc_n < HS_STOP) ? H_POL : ~H_POL;
         vsync_d    = (vc_n >= VS_START && vc_n < VS_STOP) ? V_POL : ~V_POL;
         video_on_d = vis;
         x_d        = vis ? XW'(hc_n) : '0;
         y_d        = vis ? YW'(vc_n) : '0;
      end

      line_start_d  = vga.pix_en && (hc_d == '0);
      frame_start_d = vga.pix_en && (hc_d == '0) && (vc_d == '0);
   end

   always_ff @(posedge clk_25 or negedge rst_n) begin
      if (!rst_n) begin
         hc_q          <= HCW'(H_TOTAL - 1);
         vc_q          <= VCW'(V_TOTAL - 1);
         hsync_q       <= ~H_POL;
         vsync_q       <= ~V_POL;
         video_on_q    <= 1'b0;
         x_q           <= '0;
         y_q           <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         hc_q          <= hc_d;
         vc_q          <= vc_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         video_on_q    <= video_on_d;
         x_q           <= x_d;
         y_q           <= y_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign vga.hSync       = hsync_q;
   assign vga.vSync       = vsync_q;
   assign vga.video_on    = video_on_q;
   assign vga.x           = x_q;
   assign vga.y           = y_q;
   assign vga.line_start  = line_start_q;
   assign vga.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default, small/inverted-polarity and zero-porch
// geometries checked every clock against a linear-position raster model.
module tb_vga_timing_gen;
   logic clk_25 = 1'b0;
   always #5 clk_25 = ~clk_25;
   logic rst_n;

   vga_timing_gen_if #(.XW(10), .YW(10)) if0 ();
   vga_timing_gen_if #(.XW(10), .YW(10)) if1 ();
   vga_timing_gen_if #(.XW(10), .YW(10)) if2 ();

   vga_timing_gen u_def (.clk_25(clk_25), .rst_n(rst_n), .vga(if0));

   vga_timing_gen #(
      .H_VISIBLE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_VISIBLE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .H_POL(1'b1), .V_POL(1'b1), .XW(10), .YW(10)
   ) u_small (.clk_25(clk_25), .rst_n(rst_n), .vga(if1));

   vga_timing_gen #(
      .H_VISIBLE(5), .H_FP(0), .H_SYNC(0), .H_BP(0),
      .V_VISIBLE(3), .V_FP(0), .V_SYNC(0), .V_BP(0),
      .H_POL(1'b0), .V_POL(1'b0), .XW(10), .YW(10)
   ) u_zero (.clk_25(clk_25), .rst_n(rst_n), .vga(if2));

   typedef struct packed {
      logic       hs;
      logic       vs;
      logic       von;
      logic       ls;
      logic       fs;
      logic [9:0] x;
      logic [9:0] y;
   } out_t;

   int unsigned ghv[3] = '{640, 4, 5};
   int unsigned ghf[3] = '{16, 1, 0};
   int unsigned ghs[3] = '{96, 2, 0};
   int unsigned ghb[3] = '{48, 1, 0};
   int unsigned gvv[3] = '{480, 3, 3};
   int unsigned gvf[3] = '{10, 1, 0};
   int unsigned gvs[3] = '{2, 1, 0};
   int unsigned gvb[3] = '{33, 1, 0};
   logic        gpol[3] = '{1'b0, 1'b1, 1'b0};

   int unsigned pos[3];
   out_t        exp_o[3];
   out_t        obs[3];
   logic        en[3];
   int          mode[3];
   int          per[3];
   int          last_ev[3];
   int          n_assert = 0;
   int          n_fail   = 0;
   int          cyc      = 0;

   function automatic int unsigned ht(int i);
      return ghv[i] + ghf[i] + ghs[i] + ghb[i];
   endfunction

   function automatic int unsigned vt(int i);
      return gvv[i] + gvf[i] + gvs[i] + gvb[i];
   endfunction

   // Level outputs for linear frame position p (row-major).
   function automatic out_t level_at(int i, int unsigned p);
      out_t        o;
      int unsigned hc, vc;
      hc    = p % ht(i);
      vc    = p / ht(i);
      o     = '0;
      o.hs  = (hc >= ghv[i] + ghf[i] && hc < ghv[i] + ghf[i] + ghs[i]) ? gpol[i] : ~gpol[i];
      o.vs  = (vc >= gvv[i] + gvf[i] && vc < gvv[i] + gvf[i] + gvs[i]) ? gpol[i] : ~gpol[i];
      o.von = (hc < ghv[i]) && (vc < gvv[i]);
      if (o.von) begin
         o.x = 10'(hc);
         o.y = 10'(vc);
      end
      return o;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         pos[i]      = ht(i) * vt(i) - 1;
         exp_o[i]    = '0;
         exp_o[i].hs = ~gpol[i];
         exp_o[i].vs = ~gpol[i];
         last_ev[i]  = -1;
      end
   endtask

   task automatic model_edge();
      if (rst_n) begin
         for (int i = 0; i < 3; i++) begin
            if (en[i]) begin
               pos[i]      = (pos[i] + 1) % (ht(i) * vt(i));
               exp_o[i]    = level_at(i, pos[i]);
               exp_o[i].ls = (pos[i] % ht(i)) == 0;
               exp_o[i].fs = (pos[i] == 0);
            end else begin
               exp_o[i].ls = 1'b0;
               exp_o[i].fs = 1'b0;
            end
         end
      end
   endtask

   task automatic drive();
      if0.pix_en = en[0];
      if1.pix_en = en[1];
      if2.pix_en = en[2];
   endtask

   task automatic sample_check();
      logic ev;
      obs[0] = {if0.hSync, if0.vSync, if0.video_on, if0.line_start, if0.frame_start, if0.x, if0.y};
      obs[1] = {if1.hSync, if1.vSync, if1.video_on, if1.line_start, if1.frame_start, if1.x, if1.y};
      obs[2] = {if2.hSync, if2.vSync, if2.video_on, if2.line_start, if2.frame_start, if2.x, if2.y};
      for (int i = 0; i < 3; i++) begin
         n_assert++;
         assert (obs[i] === exp_o[i]) else begin
            n_fail++;
            $error("FAIL out_d%0d cyc=%0d observed=%h expected=%h", i, cyc, obs[i], exp_o[i]);
         end
         ev = (i == 1) ? obs[i].fs : obs[i].ls;
         if (ev === 1'b1) begin
            if (per[i] != 0 && last_ev[i] >= 0) begin
               n_assert++;
               assert ((cyc - last_ev[i]) === per[i]) else begin
                  n_fail++;
                  $error("FAIL period_d%0d cyc=%0d observed=%0d expected=%0d",
                         i, cyc, cyc - last_ev[i], per[i]);
               end
            end
            last_ev[i] = cyc;
         end
      end
   endtask

   task automatic step();
      @(posedge clk_25);
      cyc++;
      model_edge();
      #1;
      sample_check();
      for (int i = 0; i < 3; i++) begin
         case (mode[i])
            1:       en[i] = 1'b1;
            2:       en[i] = (cyc % 4) == 0;
            3:       en[i] = 1'($urandom_range(1, 0));
            default: en[i] = 1'b0;
         endcase
      end
      drive();
   endtask

   task automatic set_phase(int m0, int m1, int m2, int p0, int p1, int p2);
      mode[0] = m0; mode[1] = m1; mode[2] = m2;
      per[0]  = p0; per[1]  = p1; per[2]  = p2;
      for (int i = 0; i < 3; i++) last_ev[i] = -1;
   endtask

   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) en[i] = 1'b0;
      drive();
      set_phase(0, 0, 0, 0, 0, 0);
      model_reset();

      // Reset held for 5 clocks with pix_en low.
      repeat (5) step();
      n_assert++;
      assert (if0.hSync === 1'b1 && if0.vSync === 1'b1) else begin
         n_fail++;
         $error("FAIL reset_sync observed=%b%b expected=11", if0.hSync, if0.vSync);
      end

      // Release away from the edge; pix_en high on the very first clock.
      rst_n = 1'b1;
      set_phase(1, 1, 1, 800, 48, 5);
      for (int i = 0; i < 3; i++) en[i] = 1'b1;
      drive();
      step();
      n_assert++;
      assert (if0.frame_start === 1'b1 && if0.line_start === 1'b1 && if0.video_on === 1'b1
              && if0.x === 10'd0 && if0.y === 10'd0) else begin
         n_fail++;
         $error("FAIL first_adv observed fs=%b ls=%b von=%b x=%0d y=%0d expected 1 1 1 0 0",
                if0.frame_start, if0.line_start, if0.video_on, if0.x, if0.y);
      end

      repeat (2000) step();

      // Asynchronous reset pulse mid-line, checked before any clock edge.
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      sample_check();
      repeat (2) step();
      rst_n = 1'b1;

      set_phase(2, 3, 3, 3200, 0, 0);
      repeat (7000) step();

      set_phase(3, 3, 3, 0, 0, 0);
      repeat (2000) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
